rf_wr_arbiter: RTL and testbench

Shares the single write port of the 8x16 register file between two writeback requesters (req0 = ALU, req1 = load unit) using round-robin arbitration. Granted writes are registered onto the register-file write port. An optional pending-write scoreboard tells the issue stage which destination registers still have writes in flight.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rr_arb2.sv | 27 ++
 rtl/rf_wr_arbiter.sv | 85 ++++++++
 tb/tb_rf_wr_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions for the writeback arbitration slice.
package rf_pkg;
  localparam int unsigned RF_ADDR_W = 3;
  localparam int unsigned RF_DATA_W = 16;
  localparam int unsigned RF_DEPTH  = 8;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer records the last granted requester.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  req_id_t last_grant;

  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || last_grant == REQ_LD))
      gnt[0] = 1'b1;
    else if (req[1])
      gnt[1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= REQ_LD;
    else if (advance)
      last_grant <= gnt[1] ? REQ_LD : REQ_ALU;
  end
endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin share of the register-file write port between ALU and load unit.
// Optional pending-write scoreboard enabled by defining RF_SCOREBOARD_EN.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_addr,
  input  logic [DATA_W-1:0]        req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_addr,
  input  logic [DATA_W-1:0]        req1_data,
  output logic                     req1_ready,
  output logic                     rf_wr_en,
  output logic [ADDR_W-1:0]        rf_wr_addr,
  output logic [DATA_W-1:0]        rf_wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [ADDR_W-1:0]        chk0_addr,
  input  logic [ADDR_W-1:0]        chk1_addr,
  output logic                     chk0_busy,
  output logic                     chk1_busy,
  output logic [(1<<ADDR_W)-1:0]   pending
);
  logic [1:0] gnt;
  logic       xfer;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (xfer),
    .gnt     (gnt)
  );

  // A grant is only ever given to a valid requester, so any grant is a transfer.
  assign xfer       = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_wr_en <= xfer;
      if (gnt[0]) begin
        rf_wr_addr <= req0_addr;
        rf_wr_data <= req0_data;
      end else if (gnt[1]) begin
        rf_wr_addr <= req1_addr;
        rf_wr_data <= req1_data;
      end
    end
  end

`ifdef RF_SCOREBOARD_EN
  // The set is written after the clear so a same-address collision leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (rf_wr_en)
        pending[rf_wr_addr] <= 1'b0;
      if (iss_valid)
        pending[iss_addr] <= 1'b1;
    end
  end

  assign chk0_busy = pending[chk0_addr];
  assign chk1_busy = pending[chk1_addr];
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_addr, chk0_addr, chk1_addr};
  assign pending    = '0;
  assign chk0_busy  = 1'b0;
  assign chk1_busy  = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Randomised self-checking bench for rf_wr_arbiter against a behavioural model.
module tb_rf_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic        iss_valid;
  logic [2:0]  iss_addr, chk0_addr, chk1_addr;
  logic        chk0_busy, chk1_busy;
  logic [7:0]  pending;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk0_addr(chk0_addr), .chk1_addr(chk1_addr),
    .chk0_busy(chk0_busy), .chk1_busy(chk1_busy), .pending(pending)
  );

  // Register file fed by the DUT write port.
  logic [15:0] tb_rf [8];
  initial for (int i = 0; i < 8; i++) tb_rf[i] = 16'h0;
  always @(posedge clk) if (rf_wr_en) tb_rf[rf_wr_addr] <= rf_wr_data;

  // Behavioural model: who went last, the pending write, the pending set, and the file.
  int          m_last;
  logic        m_en;
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  logic [7:0]  m_pend;
  logic [15:0] m_rf [8];
  logic        was_g0, was_g1;
  initial for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;

  function automatic logic want(input int who);
    if (who == 0) return req0_valid && (!req1_valid || m_last == 1);
    return req1_valid && (!req0_valid || m_last == 0);
  endfunction

  task automatic model_reset();
    m_last = 1; m_en = 0; m_addr = 0; m_data = 0; m_pend = 0;
  endtask

  task automatic tick();
    logic g0, g1;
    g0 = want(0);
    g1 = want(1);
`ifdef RF_SCOREBOARD_EN
    if (m_en) m_pend[m_addr] = 1'b0;
    if (iss_valid) m_pend[iss_addr] = 1'b1;
`endif
    if (m_en) m_rf[m_addr] = m_data;
    m_en = g0 || g1;
    if (g0) begin m_addr = req0_addr; m_data = req0_data; m_last = 0; end
    else if (g1) begin m_addr = req1_addr; m_data = req1_data; m_last = 1; end
    was_g0 = g0; was_g1 = g1;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; iss_valid = 0;
    req0_addr = 0; req1_addr = 0; req0_data = 0; req1_data = 0;
    iss_addr = 0; chk0_addr = 0; chk1_addr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rf_wr_en !== 1'b0) $display("FAIL reset_en: got %b want 0", rf_wr_en); else n_pass++;
    n_checks++; if (rf_wr_addr !== 3'd0) $display("FAIL reset_addr: got %0d want 0", rf_wr_addr); else n_pass++;
    n_checks++; if (rf_wr_data !== 16'h0) $display("FAIL reset_data: got %h want 0000", rf_wr_data); else n_pass++;
    n_checks++; if (pending !== 8'h00) $display("FAIL reset_pending: got %h want 00", pending); else n_pass++;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); else n_pass++;
  endtask

  task automatic test_single();
    req0_valid = 1; req0_addr = 3; req0_data = 16'hBEEF; #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); else n_pass++;
    tick();
    req0_valid = 0;
    n_checks++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 3'd3, 16'hBEEF})
      $display("FAIL single_write: got %b/%0d/%h want 1/3/beef", rf_wr_en, rf_wr_addr, rf_wr_data); else n_pass++;
    tick();
    n_checks++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b0, 3'd3, 16'hBEEF})
      $display("FAIL single_idle: got %b/%0d/%h want 0/3/beef", rf_wr_en, rf_wr_addr, rf_wr_data); else n_pass++;
    n_checks++; if (tb_rf[3] !== 16'hBEEF) $display("FAIL single_rf: got %h want beef", tb_rf[3]); else n_pass++;
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1; req0_addr = 1; req0_data = 16'h1111;
    req1_valid = 1; req1_addr = 2; req1_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL contend_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); else n_pass++;
      tick();
      n_checks++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {m_en, m_addr, m_data})
        $display("FAIL contend_write[%0d]: got %b/%0d/%h want %b/%0d/%h", i, rf_wr_en, rf_wr_addr, rf_wr_data, m_en, m_addr, m_data); else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_same_addr();
    do_reset();
    req0_valid = 1; req0_addr = 5; req0_data = 16'h00AA;
    req1_valid = 1; req1_addr = 5; req1_data = 16'h00BB; #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL same_first: got %b want 10", {req0_ready, req1_ready}); else n_pass++;
    tick();
    req0_valid = 0; #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL same_second: got %b want 01", {req0_ready, req1_ready}); else n_pass++;
    tick();
    req1_valid = 0;
    tick();
    n_checks++; if (tb_rf[5] !== 16'h00BB) $display("FAIL same_final: got %h want 00bb", tb_rf[5]); else n_pass++;
  endtask

`ifdef RF_SCOREBOARD_EN
  task automatic test_scoreboard();
    do_reset();
    chk0_addr = 4; chk1_addr = 2;
    iss_valid = 1; iss_addr = 4;
    tick();
    iss_valid = 0;
    n_checks++; if (pending !== 8'h10) $display("FAIL sb_set: got %h want 10", pending); else n_pass++;
    n_checks++; if ({chk0_busy, chk1_busy} !== 2'b10) $display("FAIL sb_busy: got %b want 10", {chk0_busy, chk1_busy}); else n_pass++;
    req1_valid = 1; req1_addr = 4; req1_data = 16'h4444;
    tick();
    req1_valid = 0;
    n_checks++; if (pending !== 8'h10) $display("FAIL sb_inflight: got %h want 10", pending); else n_pass++;
    tick();
    n_checks++; if (pending !== 8'h00) $display("FAIL sb_clear: got %h want 00", pending); else n_pass++;
    req1_valid = 1; req1_data = 16'h4545;
    tick();
    req1_valid = 0; iss_valid = 1; iss_addr = 4;
    tick();
    iss_valid = 0;
    n_checks++; if (pending !== 8'h10) $display("FAIL sb_set_wins: got %h want 10", pending); else n_pass++;
  endtask
`else
  task automatic test_scoreboard_off();
    do_reset();
    for (int a = 0; a < 8; a++) begin
      iss_valid = 1; iss_addr = 3'(a); chk0_addr = 3'(a); chk1_addr = 3'(7 - a);
      tick();
      n_checks++; if ({pending, chk0_busy, chk1_busy} !== 10'h0)
        $display("FAIL sb_off[%0d]: got %h/%b/%b want 00/0/0", a, pending, chk0_busy, chk1_busy); else n_pass++;
    end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid();
    logic [15:0] old6;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      iss_valid = 1; iss_addr = 3'(a);
      if (a == 7) begin req0_valid = 1; req0_addr = 6; req0_data = ~m_rf[6]; end
      tick();
    end
    idle_inputs();
    old6 = m_rf[6];
    n_checks++; if ({rf_wr_en, pending} !== {m_en, m_pend})
      $display("FAIL mid_pre: got %b/%h want %b/%h", rf_wr_en, pending, m_en, m_pend); else n_pass++;
    rst = 1'b1; #1;
    n_checks++; if ({rf_wr_en, pending} !== 9'h0) $display("FAIL mid_async: got %b/%h want 0/00", rf_wr_en, pending); else n_pass++;
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (tb_rf[6] !== old6) $display("FAIL mid_rf: got %h want %h", tb_rf[6], old6); else n_pass++;
    req0_valid = 1; req1_valid = 1; #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL mid_first: got %b want 10", {req0_ready, req1_ready}); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      if (!req0_valid || was_g0) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_addr = 3'($urandom); req0_data = 16'($urandom);
      end
      if (!req1_valid || was_g1) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_addr = 3'($urandom); req1_data = 16'($urandom);
      end
      iss_valid = $urandom_range(0, 1) == 1; iss_addr = 3'($urandom);
      chk0_addr = 3'($urandom); chk1_addr = 3'($urandom);
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== {want(0), want(1)})
        $display("FAIL rnd_ready[%0d]: got %b want %b", c, {req0_ready, req1_ready}, {want(0), want(1)}); else n_pass++;
      tick();
      n_checks++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {m_en, m_addr, m_data})
        $display("FAIL rnd_write[%0d]: got %b/%0d/%h want %b/%0d/%h", c, rf_wr_en, rf_wr_addr, rf_wr_data, m_en, m_addr, m_data); else n_pass++;
      n_checks++; if ({pending, chk0_busy, chk1_busy} !== {m_pend, m_pend[chk0_addr], m_pend[chk1_addr]})
        $display("FAIL rnd_sb[%0d]: got %h/%b/%b want %h/%b/%b", c, pending, chk0_busy, chk1_busy, m_pend, m_pend[chk0_addr], m_pend[chk1_addr]); else n_pass++;
    end
    idle_inputs();
    tick();
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (tb_rf[i] !== m_rf[i]) $display("FAIL rnd_rf[%0d]: got %h want %h", i, tb_rf[i], m_rf[i]); else n_pass++;
    end
  endtask

  initial begin
    was_g0 = 0; was_g1 = 0;
    test_reset();
    test_single();
    test_contention();
    test_same_addr();
`ifdef RF_SCOREBOARD_EN
    test_scoreboard();
`else
    test_scoreboard_off();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
